// File: rtl/lcd_ascii_pkg.sv
// Shared types and constants for the LCD ASCII formatter.
// States, ASCII code points and BCD sizing.
package lcd_ascii_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FMT  = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  localparam int CHARS = 5;
  localparam int BCD_W = 20;

endpackage

// File: rtl/lcd_digit_to_ascii.sv
// One 4-bit digit to its ASCII glyph.
// 0..9 map to '0'..'9', 10..15 to 'A'..'F'.
module lcd_digit_to_ascii
  import lcd_ascii_pkg::*;
(
  input  logic [3:0] iDIGIT,
  output logic [7:0] oCHAR
);

  always_comb begin
    if (iDIGIT < 4'd10) oCHAR = ASCII_ZERO + {4'h0, iDIGIT};
    else oCHAR = ASCII_A + {4'h0, iDIGIT} - 8'd10;
  end

endmodule

// File: rtl/lcd_ascii_formatter.sv
// 16-bit value to five ASCII chars, decimal or hex.
// Decimal runs a bit-serial double-dabble before formatting.
module lcd_ascii_formatter
  import lcd_ascii_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHARS = 5
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  input  logic [WIDTH-1:0]   iVALUE,
  input  logic               iHEX,
  input  logic               iBLANK,
  output logic               oBUSY,
  output logic               oDONE,
  output logic [8*CHARS-1:0] oASCII
);

  state_e state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic hex_q, hex_d;
  logic blank_q, blank_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic [3:0] cnt_q, cnt_d;
  logic [8*CHARS-1:0] ascii_q, ascii_d;
  logic done_q, done_d;

  logic [CHARS-1:0][3:0] dig;
  logic [CHARS-1:0][7:0] chr;
  logic [CHARS-1:0][7:0] txt;
  logic lead;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < CHARS; i++) begin
      if (bcd_q[4*i+:4] >= 4'd5)
        bcd_adj[4*i+:4] = bcd_q[4*i+:4] + 4'd3;
    end
  end

  // Both modes share the converters; hex has a zero top digit.
  assign dig = hex_q ? {4'h0, val_q} : bcd_q;

  for (genvar g = 0; g < CHARS; g++) begin : g_dig
    lcd_digit_to_ascii u_dig (
      .iDIGIT(dig[g]),
      .oCHAR (chr[g])
    );
  end

  always_comb begin
    txt  = chr;
    lead = blank_q;
    for (int i = CHARS - 1; i > 0; i--) begin
      if (lead && dig[i] == 4'h0) txt[i] = ASCII_SPACE;
      else lead = 1'b0;
    end
    if (hex_q) txt[CHARS-1] = ASCII_SPACE;
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    hex_d   = hex_q;
    blank_d = blank_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ascii_d = ascii_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iSTART) begin
          val_d   = iVALUE;
          hex_d   = iHEX;
          blank_d = iBLANK;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = iHEX ? FMT : CONV;
        end
      end
      CONV: begin
        bcd_d = {bcd_adj[BCD_W-2:0], val_q[WIDTH-1]};
        val_d = {val_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = FMT;
      end
      FMT: begin
        ascii_d = txt;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      val_q   <= '0;
      hex_q   <= 1'b0;
      blank_q <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ascii_q <= {CHARS{ASCII_SPACE}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ascii_q <= ascii_d;
      done_q  <= done_d;
    end
  end

  assign oBUSY  = (state_q != IDLE);
  assign oDONE  = done_q;
  assign oASCII = ascii_q;

endmodule

// File: tb/tb_lcd_ascii_formatter.sv
// Scoreboard bench for lcd_ascii_formatter.
// Stimulus queues expected text and done edge; a monitor checks.
module tb_lcd_ascii_formatter;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iSTART = 1'b0;
  logic [15:0] iVALUE = '0;
  logic        iHEX = 1'b0;
  logic        iBLANK = 1'b0;
  logic        oBUSY;
  logic        oDONE;
  logic [39:0] oASCII;

  localparam logic [39:0] SPACES = 40'h2020202020;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit rst_edge = 1'b0;
  logic [39:0] last_ascii = SPACES;

  logic [39:0] exp_q[$];
  int          edge_q[$];

  lcd_ascii_formatter #(.WIDTH(16), .CHARS(5)) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iSTART(iSTART),
    .iVALUE(iVALUE),
    .iHEX  (iHEX),
    .iBLANK(iBLANK),
    .oBUSY (oBUSY),
    .oDONE (oDONE),
    .oASCII(oASCII)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) begin
    cyc      <= cyc + 1;
    rst_edge <= iRST;
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  // Monitor: pops on every oDONE, checks hold between updates.
  always @(negedge iCLK) begin
    if (mon_en) begin
      if (oDONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(oASCII), 64'h0);
        end else begin
          logic [39:0] e;
          int ed;
          e  = exp_q.pop_front();
          ed = edge_q.pop_front();
          check("ascii", 64'(oASCII), 64'(e));
          check("done_edge", 64'(cyc), 64'(ed));
        end
        last_ascii = oASCII;
      end else if (rst_edge) begin
        last_ascii = oASCII;
      end else begin
        check("ascii_hold", 64'(oASCII), 64'(last_ascii));
      end
    end
  end

  task automatic issue(input logic [15:0] v, input logic h,
                       input logic b, input logic [39:0] e,
                       input bit push);
    iVALUE = v;
    iHEX   = h;
    iBLANK = b;
    iSTART = 1'b1;
    if (push) begin
      exp_q.push_back(e);
      edge_q.push_back(cyc + (h ? 2 : 18));
    end
    @(negedge iCLK);
    iSTART = 1'b0;
    iVALUE = ~v;
    iHEX   = ~h;
    iBLANK = ~b;
  endtask

  task automatic wait_done(input int exp_busy, input string nm);
    int n = 0;
    int busy = 0;
    while (!oDONE && n < 60) begin
      if (oBUSY) busy++;
      @(negedge iCLK);
      n++;
    end
    if (!oDONE) check({nm, "_timeout"}, 64'(n), 64'(0));
    else check({nm, "_busy"}, 64'(busy), 64'(exp_busy));
  endtask

  task automatic run(input logic [15:0] v, input logic h,
                     input logic b, input logic [39:0] e,
                     input string nm);
    @(negedge iCLK);
    issue(v, h, b, e, 1'b1);
    wait_done(h ? 1 : 17, nm);
  endtask

  initial begin
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    repeat (5) @(negedge iCLK);
    check("rst_ascii", 64'(oASCII), 64'(SPACES));
    check("rst_busy", 64'(oBUSY), 64'(0));
    check("rst_done", 64'(oDONE), 64'(0));
    mon_en = 1'b1;

    run(16'd65535, 1'b0, 1'b0, 40'h3635353335, "d65535");
    run(16'd42,    1'b0, 1'b1, 40'h2020203432, "d42_blank");
    run(16'd42,    1'b0, 1'b0, 40'h3030303432, "d42");
    run(16'd0,     1'b0, 1'b1, 40'h2020202030, "d0_blank");
    run(16'd256,   1'b0, 1'b1, 40'h2020323536, "d256_blank");
    run(16'hBEEF,  1'b1, 1'b0, 40'h2042454546, "hBEEF");
    run(16'h000A,  1'b1, 1'b1, 40'h2020202041, "h000A_blank");
    run(16'h00F0,  1'b1, 1'b0, 40'h2030304630, "h00F0");
    run(16'h0000,  1'b1, 1'b1, 40'h2020202030, "h0_blank");

    // Back-to-back hex: second start lands in the done cycle.
    run(16'h1234, 1'b1, 1'b0, 40'h2031323334, "h1234");
    issue(16'hABCD, 1'b1, 1'b0, 40'h2041424344, 1'b1);
    wait_done(1, "hABCD");

    // Start ignored while busy, then start accepted in done cycle.
    @(negedge iCLK);
    issue(16'd12345, 1'b0, 1'b0, 40'h3132333435, 1'b1);
    repeat (4) @(negedge iCLK);
    iVALUE = 16'd999;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    wait_done(12, "d12345");
    issue(16'd7, 1'b0, 1'b0, 40'h3030303037, 1'b1);
    wait_done(17, "d7_chain");

    // Reset mid-conversion aborts with no done.
    @(negedge iCLK);
    issue(16'd54321, 1'b0, 1'b0, 40'h0, 1'b0);
    repeat (7) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    check("abort_ascii", 64'(oASCII), 64'(SPACES));
    check("abort_busy", 64'(oBUSY), 64'(0));
    check("abort_done", 64'(oDONE), 64'(0));
    repeat (20) @(negedge iCLK);
    check("abort_idle_busy", 64'(oBUSY), 64'(0));
    run(16'd7, 1'b0, 1'b0, 40'h3030303037, "d7_fresh");

    repeat (3) @(negedge iCLK);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
